ff_fifo_word_serializer: RTL and testbench

//   Downstream drain stage for the flip-flop FIFO. Pops wide words through the

---
 rtl/ff_fifo_word_serializer.sv | 76 +++++++
 tb/tb_ff_fifo_word_serializer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ff_fifo_word_serializer.sv
// Drain stage for the flip-flop FIFO: pops wide words from a show-ahead read port
// and streams each one out as narrow beats, least-significant slice first.
module ff_fifo_word_serializer #(
    parameter int in_width  = 32,
    parameter int out_width = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic [in_width-1:0]  fifo_read_data,
    output logic                 fifo_pop,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [out_width-1:0] out_data,
    output logic                 out_last
);

    localparam int ratio  = in_width / out_width;
    localparam int beat_w = (ratio > 1) ? $clog2(ratio) : 1;
    localparam logic [beat_w-1:0] last_beat = beat_w'(ratio - 1);

    typedef enum logic {EMPTY, SEND} state_t;

    state_t                state_q, state_d;
    logic [beat_w-1:0]     beat_q, beat_d;
    logic [in_width-1:0]   word_q, word_d;
    logic                  loaded_q;
    logic                  at_last;
    logic                  transfer;
    logic                  free;

    assign loaded_q = (state_q == SEND);
    assign at_last  = loaded_q && (beat_q == last_beat);

    // Outputs are forced low while reset is held, even before the state clears.
    assign out_valid = !rst && loaded_q;
    assign out_last  = !rst && at_last;
    assign out_data  = rst ? '0 : word_q[beat_q*out_width +: out_width];

    assign transfer = out_valid && out_ready;
    assign free     = !loaded_q || (transfer && at_last);
    assign fifo_pop = !rst && !fifo_empty && free;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            beat_q  <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            word_q  <= word_d;
        end
    end

    // A pop takes priority: it covers both the idle load and the
    // zero-bubble reload on the final beat of the previous word.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        word_d  = word_q;
        if (fifo_pop) begin
            word_d  = fifo_read_data;
            beat_d  = '0;
            state_d = SEND;
        end else if (transfer) begin
            if (at_last) begin
                state_d = EMPTY;
                beat_d  = '0;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ff_fifo_word_serializer.sv
// Randomised scoreboard bench: a queue models the FIFO, expected beats are queued
// when words are pushed, and a negedge monitor checks every DUT handshake.
module tb_ff_fifo_word_serializer;

    localparam int in_width  = 32;
    localparam int out_width = 8;
    localparam int ratio     = in_width / out_width;

    typedef struct {
        logic [out_width-1:0] data;
        logic                 last;
    } beat_t;

    logic                 clk = 0;
    logic                 rst = 1;
    logic                 fifo_empty = 1;
    logic [in_width-1:0]  fifo_read_data = '0;
    logic                 fifo_pop;
    logic                 out_valid;
    logic                 out_ready = 0;
    logic [out_width-1:0] out_data;
    logic                 out_last;

    logic [in_width-1:0]  fifo_words[$];
    beat_t                exp_beats[$];
    int                   errors = 0;
    int                   checks = 0;
    int                   popped = 0;
    int                   completed = 0;
    int                   pushed = 0;
    bit                   pop_pending = 0;
    bit                   prev_stall = 0;
    logic [out_width-1:0] prev_data;
    logic                 prev_last;

    ff_fifo_word_serializer #(.in_width(in_width), .out_width(out_width)) dut (
        .clk(clk),
        .rst(rst),
        .fifo_empty(fifo_empty),
        .fifo_read_data(fifo_read_data),
        .fifo_pop(fifo_pop),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic update_fifo_ports();
        fifo_empty     = (fifo_words.size() == 0);
        fifo_read_data = (fifo_words.size() != 0) ? fifo_words[0] : '0;
    endtask

    task automatic push_word(input logic [in_width-1:0] w);
        beat_t b;
        fifo_words.push_back(w);
        for (int i = 0; i < ratio; i++) begin
            b.data = w[i*out_width +: out_width];
            b.last = (i == ratio - 1);
            exp_beats.push_back(b);
        end
        pushed++;
        update_fifo_ports();
    endtask

    // One clock: inputs change 1 time unit after the rising edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        if (pop_pending) begin
            void'(fifo_words.pop_front());
            pop_pending = 0;
        end
        update_fifo_ports();
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 20) begin
            applyStimulus();
            n++;
        end
        if (!out_valid) check(name, 0, 1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        out_ready = 1;
        while ((exp_beats.size() != 0 || fifo_words.size() != 0) && n < budget) begin
            applyStimulus();
            n++;
        end
        check("drain_done", exp_beats.size() + fifo_words.size(), 0);
    endtask

    // Monitor: model says a word is held whenever more words were popped than finished.
    always @(negedge clk) begin
        bit    holding;
        bit    head_last;
        bit    exp_pop;
        beat_t b;
        holding = (popped > completed);
        if (rst) begin
            check("reset_outputs", {fifo_pop, out_valid, out_last, out_data}, 0);
            if (holding) begin
                while (exp_beats.size() != 0) begin
                    b = exp_beats.pop_front();
                    if (b.last) break;
                end
                completed = popped;
            end
            prev_stall = 0;
        end else begin
            if (prev_stall)
                check("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_last, prev_data});
            check("out_valid", out_valid, holding);
            head_last = (exp_beats.size() != 0) && exp_beats[0].last;
            if (holding && out_ready) begin
                if (exp_beats.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    b = exp_beats.pop_front();
                    check("beat_data", out_data, b.data);
                    check("beat_last", out_last, b.last);
                    if (b.last) completed++;
                end
            end
            exp_pop = (fifo_words.size() != 0) && (!holding || (out_ready && head_last));
            check("fifo_pop", fifo_pop, exp_pop);
            if (fifo_pop) begin
                popped++;
                pop_pending = 1;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic checkOutput();
        check("pop_count", popped, pushed);
        check("fifo_left", fifo_words.size(), 0);
    endtask

    initial begin
        // Reset with a word already waiting: nothing may be popped.
        push_word(32'hDDCC_BBAA);
        rst = 1;
        applyStimulus();
        applyStimulus();
        rst = 0;
        out_ready = 1;
        drain(20);
        applyStimulus();
        check("idle_after_word", out_valid, 0);

        // Back-to-back words stream with no bubble.
        push_word(32'h0403_0201);
        push_word(32'h0807_0605);
        drain(30);

        // Backpressure on beat BB with a second word waiting.
        out_ready = 0;
        push_word(32'hDDCC_BBAA);
        wait_valid("wait_bp");
        out_ready = 1;
        applyStimulus();
        push_word(32'h1122_3344);
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            check("bp_data", out_data, 8'hBB);
        end
        drain(30);

        // Empty FIFO for a while, then a late word.
        for (int i = 0; i < 5; i++) applyStimulus();
        push_word(32'hA5A4_A3A2);
        drain(20);

        // Reset after the BB transfer drops the rest of the word.
        out_ready = 1;
        push_word(32'hDDCC_BBAA);
        wait_valid("wait_rst");
        applyStimulus();
        applyStimulus();
        push_word(32'h7788_99AA);
        rst = 1;
        applyStimulus();
        rst = 0;
        check("post_rst_valid", out_valid, 0);
        drain(30);
        checkOutput();

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 2) == 0 && fifo_words.size() < 4)
                push_word($urandom);
            applyStimulus();
        end
        rst = 0;
        drain(200);
        applyStimulus();
        check("final_idle", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
